// File: rtl/rv32_writeback_pkg.sv
// rv32_writeback_pkg
// Shared encodings and types for the rv32 writeback stage. The result-source
// and load-size encodings are also used by the decoder and memory stage.
// Contents:
//   RV32_RESULT_SRC_*  : writeback value source (ALU / LOAD / CSR)
//   RV32_LOAD_SIZE_*   : load access width (byte / half / word)
//   rv32_wb_t          : stage register contents {valid, rd_write, rd, value}
//   rv32_extend_16     : zero/sign extension helper for sub-word loads
package rv32_writeback_pkg;

  localparam logic [1:0] RV32_RESULT_SRC_ALU  = 2'b00;
  localparam logic [1:0] RV32_RESULT_SRC_LOAD = 2'b01;
  localparam logic [1:0] RV32_RESULT_SRC_CSR  = 2'b10;

  localparam logic [1:0] RV32_LOAD_SIZE_B = 2'b00;
  localparam logic [1:0] RV32_LOAD_SIZE_H = 2'b01;
  localparam logic [1:0] RV32_LOAD_SIZE_W = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        rd_write;
    logic [4:0]  rd;
    logic [31:0] value;
  } rv32_wb_t;

  // Extend a byte (is_byte=1, data in [7:0]) or halfword (data in [15:0])
  // to 32 bits; zero-extends when is_unsigned is set, else sign-extends.
  function automatic logic [31:0] rv32_extend_16(input logic [15:0] data,
                                                 input logic        is_byte,
                                                 input logic        is_unsigned);
    logic [31:0] ext;
    if (is_byte) begin
      ext = is_unsigned ? {24'h000000, data[7:0]} : {{24{data[7]}}, data[7:0]};
    end else begin
      ext = is_unsigned ? {16'h0000, data} : {{16{data[15]}}, data};
    end
    return ext;
  endfunction

endpackage

// File: rtl/rv32_writeback_if.sv
// rv32_writeback_if
// Bundle of the memory-stage -> writeback inputs and the writeback outputs
// (register-file write port, retire pulse, forwarding to execute).
// Modports:
//   master : memory-stage / environment side (drives *_in, observes *_out)
//   slave  : writeback stage side (observes *_in, drives *_out)
interface rv32_writeback_if;

  logic        valid_in;
  logic        stall_in;
  logic        flush_in;
  logic        rd_write_in;
  logic [4:0]  rd_in;
  logic [1:0]  result_src_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [31:0] alu_result_in;
  logic [31:0] mem_read_value_in;
  logic [31:0] csr_read_value_in;

  logic        rd_write_out;
  logic [4:0]  rd_out;
  logic [31:0] rd_value_out;
  logic        instr_retired_out;
  logic        fwd_valid_out;
  logic [4:0]  fwd_rd_out;
  logic [31:0] fwd_value_out;

  modport master (
    output valid_in, stall_in, flush_in, rd_write_in, rd_in, result_src_in,
           load_size_in, load_unsigned_in, alu_result_in, mem_read_value_in,
           csr_read_value_in,
    input  rd_write_out, rd_out, rd_value_out, instr_retired_out,
           fwd_valid_out, fwd_rd_out, fwd_value_out
  );

  modport slave (
    input  valid_in, stall_in, flush_in, rd_write_in, rd_in, result_src_in,
           load_size_in, load_unsigned_in, alu_result_in, mem_read_value_in,
           csr_read_value_in,
    output rd_write_out, rd_out, rd_value_out, instr_retired_out,
           fwd_valid_out, fwd_rd_out, fwd_value_out
  );

endinterface

// File: rtl/rv32_load_extend.sv
// rv32_load_extend
// Combinational extractor/extender for load data. Picks the addressed
// byte/half out of the aligned data-bus word and zero/sign extends it.
// Ports:
//   word_i     : raw aligned data-bus word
//   offset_i   : byte offset within the word (effective address [1:0])
//   size_i     : RV32_LOAD_SIZE_B/H/W
//   unsigned_i : zero-extend instead of sign-extend
//   value_o    : 32-bit register value (X for the reserved size encoding)
module rv32_load_extend
  import rv32_writeback_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte and halfword lane selection; offset_i[0] is ignored for halves
  // because misaligned accesses trap before reaching this stage.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (offset_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
  end

  // Width selection and extension.
  always_comb begin
    value_o = 32'h00000000;
    case (size_i)
      RV32_LOAD_SIZE_B: value_o = rv32_extend_16({8'h00, byte_s}, 1'b1, unsigned_i);
      RV32_LOAD_SIZE_H: value_o = rv32_extend_16(half_s, 1'b0, unsigned_i);
      RV32_LOAD_SIZE_W: value_o = word_i;
      default:          value_o = {32{1'bx}};
    endcase
  end

endmodule

// File: rtl/rv32_writeback.sv
// rv32_writeback
// Final rv32 pipeline stage: registers the memory-stage result, selects the
// write-back value (ALU / extended load / CSR) and drives the register-file
// write port plus the one-cycle instruction-retired pulse.
// Ports:
//   clk   : core clock, rising edge
//   reset : synchronous, active-high; discards any in-flight instruction
//   wb    : rv32_writeback_if.slave (memory-stage inputs, regfile/retire/fwd outputs)
// Build option:
//   RV32_WB_FORWARD_EN : when defined, fwd_* mirror the register-file write
//                        port; otherwise fwd_* are tied to 0.
// All outputs come from the stage register (at most ANDed together), so no
// input reaches an output combinationally.
module rv32_writeback
  import rv32_writeback_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  rv32_writeback_if.slave  wb
);

  logic        accept_s;
  logic [31:0] load_value_s;
  logic [31:0] result_s;
  rv32_wb_t    wb_d;
  rv32_wb_t    wb_q;

  // A stalled or flushed instruction becomes a bubble; both together still
  // yield a single bubble.
  assign accept_s = wb.valid_in & ~wb.stall_in & ~wb.flush_in;

  rv32_load_extend u_load_extend (
    .word_i     (wb.mem_read_value_in),
    .offset_i   (wb.alu_result_in[1:0]),
    .size_i     (wb.load_size_in),
    .unsigned_i (wb.load_unsigned_in),
    .value_o    (load_value_s)
  );

  // Write-back value select ahead of the stage register.
  always_comb begin
    result_s = 32'h00000000;
    case (wb.result_src_in)
      RV32_RESULT_SRC_ALU:  result_s = wb.alu_result_in;
      RV32_RESULT_SRC_LOAD: result_s = load_value_s;
      RV32_RESULT_SRC_CSR:  result_s = wb.csr_read_value_in;
      default:              result_s = {32{1'bx}};
    endcase
  end

  // Next stage-register contents; a bubble clears valid and the write enable.
  always_comb begin
    wb_d          = '0;
    wb_d.valid    = accept_s;
    wb_d.rd_write = accept_s & wb.rd_write_in;
    wb_d.rd       = wb.rd_in;
    wb_d.value    = result_s;
  end

  // Stage register with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  // x0 is hard-wired zero, so a write to it is suppressed here.
  assign wb.rd_write_out      = wb_q.valid & wb_q.rd_write & (wb_q.rd != 5'd0);
  assign wb.rd_out            = wb_q.rd;
  assign wb.rd_value_out      = wb_q.value;
  assign wb.instr_retired_out = wb_q.valid;

`ifdef RV32_WB_FORWARD_EN
  assign wb.fwd_valid_out = wb.rd_write_out;
  assign wb.fwd_rd_out    = wb.rd_out;
  assign wb.fwd_value_out = wb.rd_value_out;
`else
  // Execute relies on register-file write-before-read instead.
  assign wb.fwd_valid_out = 1'b0;
  assign wb.fwd_rd_out    = 5'd0;
  assign wb.fwd_value_out = 32'h00000000;
`endif

endmodule

// File: tb/tb_rv32_writeback.sv
// tb_rv32_writeback
// Self-checking bench for rv32_writeback: reset, directed vector table,
// bubble sequences and randomized traffic against a reference model.
module tb_rv32_writeback;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rv32_writeback_if wbif ();

  rv32_writeback dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, stall, flush, rd_write;
    logic [4:0]  rd;
    logic [1:0]  src, size;
    logic        uns;
    logic [31:0] alu, mem, csr;
    logic        exp_we;
    logic [31:0] exp_val;
    logic        exp_ret;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Forwarding outputs checked in every sampled cycle.
  task automatic check_fwd();
`ifdef RV32_WB_FORWARD_EN
    check("fwd_valid", {31'd0, wbif.fwd_valid_out}, {31'd0, wbif.rd_write_out});
    check("fwd_rd", {27'd0, wbif.fwd_rd_out}, {27'd0, wbif.rd_out});
    check("fwd_value", wbif.fwd_value_out, wbif.rd_value_out);
`else
    check("fwd_valid", {31'd0, wbif.fwd_valid_out}, 32'd0);
    check("fwd_rd", {27'd0, wbif.fwd_rd_out}, 32'd0);
    check("fwd_value", wbif.fwd_value_out, 32'd0);
`endif
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic w,
                       input logic [4:0] rd, input logic [1:0] src, input logic [1:0] size,
                       input logic uns, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] csr);
    wbif.valid_in          = v;
    wbif.stall_in          = s;
    wbif.flush_in          = f;
    wbif.rd_write_in       = w;
    wbif.rd_in             = rd;
    wbif.result_src_in     = src;
    wbif.load_size_in      = size;
    wbif.load_unsigned_in  = uns;
    wbif.alu_result_in     = alu;
    wbif.mem_read_value_in = mem;
    wbif.csr_read_value_in = csr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: value a load/ALU/CSR instruction writes back.
  function automatic logic [31:0] model_value(input logic [1:0] src, input logic [1:0] size,
                                              input logic uns, input logic [31:0] alu,
                                              input logic [31:0] mem, input logic [31:0] csr);
    int          bits;
    int          shift;
    logic [31:0] one;
    logic [31:0] mask;
    logic [31:0] v;
    if (src == 2'd0) return alu;
    if (src == 2'd2) return csr;
    one   = 32'd1;
    bits  = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    shift = (size == 2'd0) ? 8 * int'(alu[1:0]) : (size == 2'd1) ? 16 * int'(alu[1]) : 0;
    v = mem >> shift;
    if (bits < 32) begin
      mask = (one << bits) - 32'd1;
      v = v & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    vec_t        t;
    logic        seq_ret[4];
    logic        exp_we, exp_ret;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val;
    logic        r_v, r_s, r_f, r_w, r_u;
    logic [4:0]  r_rd;
    logic [1:0]  r_src, r_size;
    logic [31:0] r_alu, r_mem, r_csr;

    checks = 0;
    errors = 0;

    // Reset held two cycles with a valid instruction presented.
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 2'd0, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_we", {31'd0, wbif.rd_write_out}, 32'd0);
      check("reset_ret", {31'd0, wbif.instr_retired_out}, 32'd0);
      check("reset_rd", {27'd0, wbif.rd_out}, 32'd0);
      check("reset_val", wbif.rd_value_out, 32'd0);
      check_fwd();
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();

    // Directed vectors: {valid,stall,flush,we,rd,src,size,uns,alu,mem,csr, exp_we,exp_val,exp_ret}
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,5'd5, 2'd0,2'd2,1'b0,32'h12345678,32'h0,32'h0, 1'b1,32'h12345678,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,5'd5, 2'd0,2'd2,1'b0,32'h12345678,32'h0,32'h0, 1'b0,32'h0,1'b0});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,5'd10,2'd1,2'd0,1'b0,32'h00001003,32'h80FF7F01,32'h0, 1'b1,32'hFFFFFF80,1'b1});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,5'd11,2'd1,2'd0,1'b1,32'h00001003,32'h80FF7F01,32'h0, 1'b1,32'h00000080,1'b1});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,5'd12,2'd1,2'd1,1'b0,32'h00001002,32'h80FF7F01,32'h0, 1'b1,32'hFFFF80FF,1'b1});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,5'd13,2'd1,2'd1,1'b1,32'h00001000,32'h80FF7F01,32'h0, 1'b1,32'h00007F01,1'b1});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,5'd14,2'd1,2'd2,1'b0,32'h00001000,32'h80FF7F01,32'h0, 1'b1,32'h80FF7F01,1'b1});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,5'd0, 2'd2,2'd2,1'b0,32'h0,32'h0,32'h40100100, 1'b0,32'h40100100,1'b1});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b0,5'd0, 2'd0,2'd2,1'b0,32'h00000055,32'h0,32'h0, 1'b0,32'h00000055,1'b1});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b0,5'd9, 2'd0,2'd2,1'b0,32'h00000066,32'h0,32'h0, 1'b0,32'h00000066,1'b1});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b1,5'd9, 2'd0,2'd2,1'b0,32'h00000077,32'h0,32'h0, 1'b0,32'h0,1'b0});

    foreach (vecs[i]) begin
      t = vecs[i];
      drive(t.valid, t.stall, t.flush, t.rd_write, t.rd, t.src, t.size, t.uns, t.alu, t.mem, t.csr);
      step();
      check($sformatf("vec%0d_we", i), {31'd0, wbif.rd_write_out}, {31'd0, t.exp_we});
      check($sformatf("vec%0d_ret", i), {31'd0, wbif.instr_retired_out}, {31'd0, t.exp_ret});
      if (t.exp_ret) begin
        check($sformatf("vec%0d_rd", i), {27'd0, wbif.rd_out}, {27'd0, t.rd});
        check($sformatf("vec%0d_val", i), wbif.rd_value_out, t.exp_val);
      end
      check_fwd();
    end

    // Back-to-back valid with stall in cycle 2 and flush in cycle 4.
    seq_ret = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, (c == 1), (c == 3), 1'b1, 5'(c + 1), 2'd0, 2'd2, 1'b0, 32'(c + 100), 32'h0, 32'h0);
      step();
      check($sformatf("bub%0d_ret", c), {31'd0, wbif.instr_retired_out}, {31'd0, seq_ret[c]});
      check($sformatf("bub%0d_we", c), {31'd0, wbif.rd_write_out}, {31'd0, seq_ret[c]});
      check_fwd();
    end

    // Single retire pulse: valid then idle must give 1 then 0.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 2'd0, 2'd2, 1'b0, 32'hA5A5A5A5, 32'h0, 32'h0);
    step();
    check("pulse_hi", {31'd0, wbif.instr_retired_out}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 2'd0, 2'd2, 1'b0, 32'hA5A5A5A5, 32'h0, 32'h0);
    step();
    check("pulse_lo", {31'd0, wbif.instr_retired_out}, 32'd0);
    check("pulse_we_lo", {31'd0, wbif.rd_write_out}, 32'd0);

    // Mid-stream reset discards the in-flight instruction.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 2'd0, 2'd2, 1'b0, 32'h11112222, 32'h0, 32'h0);
    step();
    check("mid_pre_ret", {31'd0, wbif.instr_retired_out}, 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_ret", {31'd0, wbif.instr_retired_out}, 32'd0);
    check("mid_rst_we", {31'd0, wbif.rd_write_out}, 32'd0);
    check("mid_rst_val", wbif.rd_value_out, 32'd0);
    reset = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      r_v    = ($urandom_range(0, 3) != 0);
      r_s    = ($urandom_range(0, 4) == 0);
      r_f    = ($urandom_range(0, 5) == 0);
      r_w    = ($urandom_range(0, 3) != 0);
      r_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      r_src  = 2'($urandom_range(0, 2));
      r_size = 2'($urandom_range(0, 2));
      r_u    = 1'($urandom);
      r_alu  = $urandom;
      r_mem  = $urandom;
      r_csr  = $urandom;
      drive(r_v, r_s, r_f, r_w, r_rd, r_src, r_size, r_u, r_alu, r_mem, r_csr);
      exp_ret = r_v && !r_s && !r_f;
      exp_we  = exp_ret && r_w && (r_rd != 5'd0);
      exp_rd  = r_rd;
      exp_val = model_value(r_src, r_size, r_u, r_alu, r_mem, r_csr);
      step();
      check("rnd_ret", {31'd0, wbif.instr_retired_out}, {31'd0, exp_ret});
      check("rnd_we", {31'd0, wbif.rd_write_out}, {31'd0, exp_we});
      if (exp_ret) begin
        check("rnd_rd", {27'd0, wbif.rd_out}, {27'd0, exp_rd});
        check("rnd_val", wbif.rd_value_out, exp_val);
      end
      check_fwd();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
